// File: rtl/fila_pkg.sv
// Shared definitions for the lift request-intake stage.
//   estado_t : FSM state encoding, also exported on db_estado
//   MOT_*    : reason codes reported on motivo when a request is dropped
package fila_pkg;

    typedef enum logic [2:0] {
        DESLIGADO = 3'b000,
        ESPERA    = 3'b001,
        CAPTURA   = 3'b010,
        CHECA     = 3'b011,
        GRAVA     = 3'b100,
        DESCARTA  = 3'b101
    } estado_t;

    localparam logic [1:0] MOT_NENHUM    = 2'b00;
    localparam logic [1:0] MOT_INVALIDO  = 2'b01;
    localparam logic [1:0] MOT_CHEIA     = 2'b10;
    localparam logic [1:0] MOT_DUPLICADO = 2'b11;

endpackage

// File: rtl/fila_requisicoes_sincroniza_borda.sv
// Two-flop synchronizer followed by a rising-edge detector.
//   clock   in  system clock
//   reset   in  asynchronous active-low reset
//   entrada in  asynchronous level input
//   borda   out one-cycle pulse per rising edge of entrada (2-3 cycles later)
module sincroniza_borda (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic borda
);

    // sinc[0], sinc[1]: synchronizer; sinc[2]: previous synchronized value
    logic [2:0] sinc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc <= 3'b000;
        end else begin
            sinc <= {sinc[1:0], entrada};
        end
    end

    assign borda = sinc[1] & ~sinc[2];

endmodule

// File: rtl/fila_requisicoes.sv
// Request-intake stage for the lift controller: synchronizes the operator
// strobe, validates each (origem, destino) pair and queues accepted pairs.
//   clock, reset         system clock / asynchronous active-low reset
//   iniciar              enable level; low flushes the queue and idles the FSM
//   novaEntrada          asynchronous request strobe
//   origem, destino      requested floors, stable around the strobe
//   pop                  consumer takes the head entry
//   valido               queue non-empty, head presented on cab_origem/cab_destino
//   contagem, cheio      occupancy and full flag
//   rejeitado, motivo    drop pulse and sticky reason code
//   db_estado            current FSM state
//
// state     | meaning
// DESLIGADO | disabled, queue held empty
// ESPERA    | waiting for a request edge
// CAPTURA   | registering origem/destino
// CHECA     | validity / full / duplicate evaluation
// GRAVA     | writing the pair into the queue
// DESCARTA  | dropping the pair, rejeitado pulse
module fila_requisicoes
    import fila_pkg::*;
#(
    parameter int ANDAR_W      = 4,
    parameter int PROFUNDIDADE = 4,
    parameter int MAX_ANDAR    = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            iniciar,
    input  logic                            novaEntrada,
    input  logic [ANDAR_W-1:0]              origem,
    input  logic [ANDAR_W-1:0]              destino,
    input  logic                            pop,
    output logic                            valido,
    output logic [ANDAR_W-1:0]              cab_origem,
    output logic [ANDAR_W-1:0]              cab_destino,
    output logic [$clog2(PROFUNDIDADE):0]   contagem,
    output logic                            cheio,
    output logic                            rejeitado,
    output logic [1:0]                      motivo,
    output logic [2:0]                      db_estado
);

    localparam int PTR_W = $clog2(PROFUNDIDADE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ANDAR_W-1:0] ANDAR_MAX = ANDAR_W'(MAX_ANDAR);
    localparam logic [CNT_W-1:0]   CNT_CHEIO = CNT_W'(PROFUNDIDADE);

    estado_t estado, proximo;

    logic                 borda;
    logic [ANDAR_W-1:0]   req_origem, req_destino;
    logic [ANDAR_W-1:0]   mem_origem  [PROFUNDIDADE];
    logic [ANDAR_W-1:0]   mem_destino [PROFUNDIDADE];
    logic [PTR_W-1:0]     wptr, rptr;
    logic                 invalido, duplicado;
    logic [1:0]           motivo_checa;
    logic                 captura_en, grava_en, motivo_en;
    logic                 pop_ok;

    sincroniza_borda u_sincroniza_borda (
        .clock   (clock),
        .reset   (reset),
        .entrada (novaEntrada),
        .borda   (borda)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= DESLIGADO;
        end else begin
            estado <= proximo;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        proximo = estado;
        if (!iniciar) begin
            proximo = DESLIGADO;
        end else begin
            case (estado)
                DESLIGADO: proximo = ESPERA;
                ESPERA:    if (borda) proximo = CAPTURA;
                CAPTURA:   proximo = CHECA;
                CHECA:     proximo = (motivo_checa == MOT_NENHUM) ? GRAVA : DESCARTA;
                GRAVA:     proximo = ESPERA;
                DESCARTA:  proximo = ESPERA;
                default:   proximo = DESLIGADO;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // motivo is loaded on the edge into DESCARTA so it is already valid
    // during the rejeitado pulse.
    always_comb begin
        captura_en = 1'b0;
        grava_en   = 1'b0;
        motivo_en  = 1'b0;
        rejeitado  = 1'b0;
        case (estado)
            CAPTURA:  captura_en = 1'b1;
            CHECA:    motivo_en  = iniciar && (motivo_checa != MOT_NENHUM);
            GRAVA:    grava_en   = iniciar;
            DESCARTA: rejeitado  = 1'b1;
            default:  ;
        endcase
    end

    // ---------------- request checks ----------------
    assign invalido = (req_origem == req_destino) ||
                      (req_origem > ANDAR_MAX)    ||
                      (req_destino > ANDAR_MAX);

    // Only slots rptr .. rptr+contagem-1 hold live entries.
    always_comb begin
        duplicado = 1'b0;
        for (int k = 0; k < PROFUNDIDADE; k++) begin
            if ((CNT_W'(k) < contagem) &&
                (mem_origem[rptr + PTR_W'(k)]  == req_origem) &&
                (mem_destino[rptr + PTR_W'(k)] == req_destino)) begin
                duplicado = 1'b1;
            end
        end
    end

    always_comb begin
        motivo_checa = MOT_NENHUM;
        if (invalido) begin
            motivo_checa = MOT_INVALIDO;
        end else if (cheio) begin
            motivo_checa = MOT_CHEIA;
        end else if (duplicado) begin
            motivo_checa = MOT_DUPLICADO;
        end
    end

    // ---------------- queue datapath ----------------
    assign valido = (contagem != '0);
    assign cheio  = (contagem == CNT_CHEIO);
    assign pop_ok = pop && valido;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_origem  <= '0;
            req_destino <= '0;
            wptr        <= '0;
            rptr        <= '0;
            contagem    <= '0;
            motivo      <= MOT_NENHUM;
            for (int i = 0; i < PROFUNDIDADE; i++) begin
                mem_origem[i]  <= '0;
                mem_destino[i] <= '0;
            end
        end else begin
            if (captura_en) begin
                req_origem  <= origem;
                req_destino <= destino;
            end
            if (motivo_en) begin
                motivo <= motivo_checa;
            end
            if (!iniciar) begin
                wptr     <= '0;
                rptr     <= '0;
                contagem <= '0;
            end else begin
                if (grava_en) begin
                    mem_origem[wptr]  <= req_origem;
                    mem_destino[wptr] <= req_destino;
                    wptr              <= wptr + PTR_W'(1);
                end
                if (pop_ok) begin
                    rptr <= rptr + PTR_W'(1);
                end
                case ({grava_en, pop_ok})
                    2'b10:   contagem <= contagem + CNT_W'(1);
                    2'b01:   contagem <= contagem - CNT_W'(1);
                    default: contagem <= contagem;
                endcase
            end
        end
    end

    assign cab_origem  = valido ? mem_origem[rptr]  : '0;
    assign cab_destino = valido ? mem_destino[rptr] : '0;
    assign db_estado   = estado;

endmodule

// File: tb/tb_fila_requisicoes.sv
// Bench for fila_requisicoes: a queue-based model of the request stage is
// compared against every DUT output on each falling clock edge, and
// directed scenarios pin selected values with literal expectations.
module tb_fila_requisicoes;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       novaEntrada = 1'b0;
    logic       pop = 1'b0;
    logic [3:0] origem = 4'd0;
    logic [3:0] destino = 4'd0;

    logic       valido;
    logic [3:0] cab_origem, cab_destino;
    logic [2:0] contagem;
    logic       cheio, rejeitado;
    logic [1:0] motivo;
    logic [2:0] db_estado;

    fila_requisicoes #(.ANDAR_W(4), .PROFUNDIDADE(4), .MAX_ANDAR(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .novaEntrada (novaEntrada),
        .origem      (origem),
        .destino     (destino),
        .pop         (pop),
        .valido      (valido),
        .cab_origem  (cab_origem),
        .cab_destino (cab_destino),
        .contagem    (contagem),
        .cheio       (cheio),
        .rejeitado   (rejeitado),
        .motivo      (motivo),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int rej_count = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase_m uses the state numbering from the design description:
    // 0 off, 1 wait, 2 capture, 3 check, 4 write, 5 drop.
    logic [7:0] q[$];
    logic [7:0] cap_m = 8'd0;
    int         phase_m = 0;
    logic [1:0] mot_m = 2'd0;
    logic       smp0 = 1'b0, smp1 = 1'b0, smp2 = 1'b0;

    function automatic int reason(input logic [7:0] p);
        if (p[7:4] == p[3:0] || p[7:4] > 4'd8 || p[3:0] > 4'd8) return 1;
        if (q.size() >= 4) return 2;
        foreach (q[i]) if (q[i] == p) return 3;
        return 0;
    endfunction

    always @(posedge clock or negedge reset) begin
        bit edge_seen;
        bit pop_m;
        bit push_m;
        int r;
        if (!reset) begin
            q.delete();
            cap_m = 8'd0;
            phase_m = 0;
            mot_m = 2'd0;
            smp0 = 1'b0;
            smp1 = 1'b0;
            smp2 = 1'b0;
        end else begin
            // a rise seen two samples back is the request edge for this cycle
            edge_seen = smp1 & ~smp2;
            smp2 = smp1;
            smp1 = smp0;
            smp0 = novaEntrada;
            pop_m = pop && (q.size() > 0);
            push_m = 1'b0;
            if (!iniciar) begin
                q.delete();
                phase_m = 0;
            end else begin
                case (phase_m)
                    0: phase_m = 1;
                    1: if (edge_seen) phase_m = 2;
                    2: begin cap_m = {origem, destino}; phase_m = 3; end
                    3: begin
                        r = reason(cap_m);
                        if (r == 0) phase_m = 4;
                        else begin mot_m = 2'(r); phase_m = 5; end
                    end
                    4: begin push_m = 1'b1; phase_m = 1; end
                    default: phase_m = 1;
                endcase
                if (pop_m) void'(q.pop_front());
                if (push_m) q.push_back(cap_m);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (run_chk) begin
            if (rejeitado) rej_count++;
            chk("valido", int'(valido), int'(q.size() > 0));
            chk("contagem", int'(contagem), q.size());
            chk("cheio", int'(cheio), int'(q.size() == 4));
            chk("cab_origem", int'(cab_origem), (q.size() > 0) ? int'(q[0][7:4]) : 0);
            chk("cab_destino", int'(cab_destino), (q.size() > 0) ? int'(q[0][3:0]) : 0);
            chk("rejeitado", int'(rejeitado), int'(phase_m == 5));
            chk("motivo", int'(motivo), int'(mot_m));
            chk("db_estado", int'(db_estado), phase_m);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic req(input logic [3:0] o, input logic [3:0] d);
        @(negedge clock);
        origem = o;
        destino = d;
        novaEntrada = 1'b1;
        repeat (3) @(negedge clock);
        novaEntrada = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic do_pop();
        @(negedge clock);
        pop = 1'b1;
        @(negedge clock);
        pop = 1'b0;
    endtask

    task automatic flush();
        @(negedge clock);
        iniciar = 1'b0;
        @(negedge clock);
        iniciar = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int r0;
        #1 reset = 1'b0;
        run_chk = 1'b1;
        repeat (10) @(negedge clock);
        chk("reset db_estado", int'(db_estado), 0);
        chk("reset motivo", int'(motivo), 0);
        reset = 1'b1;
        iniciar = 1'b1;
        repeat (3) @(negedge clock);

        // 1: single held strobe gives one entry, visible at E+4
        r0 = rej_count;
        origem = 4'd1;
        destino = 4'd4;
        @(negedge clock);
        novaEntrada = 1'b1;
        repeat (5) @(negedge clock);
        chk("t1 valido before E+4", int'(valido), 0);
        @(negedge clock);
        chk("t1 valido at E+4", int'(valido), 1);
        chk("t1 cab_origem", int'(cab_origem), 1);
        chk("t1 cab_destino", int'(cab_destino), 4);
        repeat (44) @(negedge clock);
        novaEntrada = 1'b0;
        repeat (6) @(negedge clock);
        chk("t1 contagem", int'(contagem), 1);
        chk("t1 no reject", rej_count - r0, 0);

        // 2: invalid pairs
        r0 = rej_count;
        req(4'd3, 4'd3);
        chk("t2 motivo same floor", int'(motivo), 1);
        req(4'd2, 4'd9);
        chk("t2 motivo above max", int'(motivo), 1);
        chk("t2 reject pulses", rej_count - r0, 2);
        chk("t2 contagem", int'(contagem), 1);

        // 3: overflow
        flush();
        req(4'd1, 4'd4);
        req(4'd2, 4'd6);
        req(4'd8, 4'd3);
        req(4'd0, 4'd5);
        chk("t3 cheio", int'(cheio), 1);
        req(4'd4, 4'd7);
        chk("t3 motivo overflow", int'(motivo), 2);
        chk("t3 head origem", int'(cab_origem), 1);
        chk("t3 head destino", int'(cab_destino), 4);
        chk("t3 contagem", int'(contagem), 4);

        // 4: duplicate
        flush();
        req(4'd2, 4'd6);
        req(4'd2, 4'd6);
        chk("t4 motivo duplicate", int'(motivo), 3);
        chk("t4 contagem", int'(contagem), 1);
        do_pop();
        chk("t4 valido after pop", int'(valido), 0);
        req(4'd2, 4'd6);
        chk("t4 re-accepted", int'(contagem), 1);

        // 5: pop in the same cycle as the write, then pointer wrap
        flush();
        req(4'd1, 4'd4);
        @(negedge clock);
        origem = 4'd8;
        destino = 4'd3;
        novaEntrada = 1'b1;
        repeat (3) @(negedge clock);
        novaEntrada = 1'b0;
        repeat (2) @(negedge clock);
        chk("t5 in write state", int'(db_estado), 4);
        pop = 1'b1;
        @(negedge clock);
        pop = 1'b0;
        chk("t5 contagem kept", int'(contagem), 1);
        chk("t5 head origem", int'(cab_origem), 8);
        chk("t5 head destino", int'(cab_destino), 3);
        repeat (4) @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            req(4'(i), 4'(i + 1));
            do_pop();
        end
        chk("t5 wrap head origem", int'(cab_origem), 5);
        chk("t5 wrap head destino", int'(cab_destino), 6);
        chk("t5 wrap contagem", int'(contagem), 1);

        // 6: iniciar drop flushes; async reset during the check
        flush();
        req(4'd1, 4'd2);
        req(4'd3, 4'd4);
        req(4'd5, 4'd6);
        chk("t6 three stored", int'(contagem), 3);
        @(negedge clock);
        iniciar = 1'b0;
        @(negedge clock);
        chk("t6 flush contagem", int'(contagem), 0);
        chk("t6 flush valido", int'(valido), 0);
        chk("t6 flush db_estado", int'(db_estado), 0);
        iniciar = 1'b1;
        repeat (2) @(negedge clock);
        req(4'd1, 4'd2);
        @(negedge clock);
        origem = 4'd2;
        destino = 4'd3;
        novaEntrada = 1'b1;
        repeat (4) @(negedge clock);
        chk("t6 in check state", int'(db_estado), 3);
        #2 reset = 1'b0;
        #1;
        chk("t6 async valido", int'(valido), 0);
        chk("t6 async contagem", int'(contagem), 0);
        chk("t6 async db_estado", int'(db_estado), 0);
        chk("t6 async motivo", int'(motivo), 0);
        chk("t6 async cab", int'({cab_origem, cab_destino}), 0);
        novaEntrada = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        req(4'd3, 4'd5);
        chk("t6 after reset accept", int'(contagem), 1);
        chk("t6 after reset head", int'(cab_origem), 3);

        run_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fila_requisicoes.md
Name: fila_requisicoes

Overview:
- Upstream request-intake stage for the lift controller (circuito_final).
- Takes the raw operator inputs origem, destino and the novaEntrada strobe, and synchronizes and edge-detects novaEntrada.
- Validates each (origem, destino) pair and stores accepted pairs in a small FIFO.
- The controller consumes the FIFO head through a valid/pop handshake; rejected requests are reported with a reason code.

Parameters:
- ANDAR_W, 4, width of the floor fields.
- PROFUNDIDADE, 4, FIFO depth in entries. Must be a power of two, ≥2.
- MAX_ANDAR, 8, highest legal floor number. Floors 0..MAX_ANDAR are legal.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- iniciar  in  1  enable level. While 0, the block is idle and the FIFO is flushed.
- novaEntrada  in  1  asynchronous request strobe, level-held by the operator.
- origem  in  ANDAR_W  requested pickup floor; stable before and during the strobe.
- destino  in  ANDAR_W  requested drop floor; stable before and during the strobe.
- pop  in  1  consumer accepts the head entry this cycle.
- valido  out  1  FIFO is non-empty; the head is presented.
- cab_origem  out  ANDAR_W  head entry, origin floor.
- cab_destino  out  ANDAR_W  head entry, destination floor.
- contagem  out  log2(PROFUNDIDADE)+1  number of stored entries.
- cheio  out  1  contagem == PROFUNDIDADE.
- rejeitado  out  1  one-cycle pulse when a request is dropped.
- motivo  out  2  reason for the last drop, held until the next drop: 01 invalid, 10 overflow, 11 duplicate.
- db_estado  out  3  current FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): all outputs, pointers, synchronizer flops and the state are cleared. State = DESLIGADO, valido=0, contagem=0, motivo=00.
  - Reset asserted mid-operation discards any in-flight capture and the whole FIFO.
- Synchronizer: novaEntrada passes through a 2-FF synchronizer, then a rising-edge detector. This produces a one-cycle pulse `borda` two to three cycles after the input rises.
  - A held-high strobe yields exactly one request.
  - A new request requires novaEntrada to fall and rise again.
- FSM states:
  - DESLIGADO: leave when iniciar=1 → ESPERA.
  - ESPERA: on borda → CAPTURA.
  - CAPTURA: register origem and destino → CHECA.
  - CHECA: evaluate the checks in this priority order:
    1. origem==destino, or either floor > MAX_ANDAR → DESCARTA, motivo=01.
    2. Else cheio → DESCARTA, motivo=10.
    3. Else the pair equals any stored entry (compared against the contents at the start of this cycle) → DESCARTA, motivo=11.
    4. Else → GRAVA.
  - GRAVA: write the pair at the write pointer; wptr++ and contagem++ → ESPERA.
  - DESCARTA: rejeitado=1 for exactly this cycle; update motivo → ESPERA.
- Latency: borda in cycle E → entry written at the end of cycle E+3 → valido=1 and the head visible from cycle E+4 (when the FIFO was empty).
- Edges during CAPTURA/CHECA/GRAVA/DESCARTA are ignored (not queued). The operator must space requests by ≥6 cycles.
- iniciar=0 from any state → DESLIGADO at the next edge. The FIFO is flushed synchronously (pointers=0, contagem=0); rejeitado is not pulsed.
- Handshake:
  - cab_origem/cab_destino show the entry at rptr whenever valido=1. Their value when valido=0 is don't-care; drive 0.
  - pop with valido=1 advances rptr and decrements contagem at the clock edge.
  - pop with valido=0 is ignored.
- Simultaneous GRAVA and pop: both take effect; contagem is unchanged.
  - A GRAVA cannot occur while cheio, so there is no write to a full FIFO.
  - A pop in the same cycle as CHECA does not free a slot for that check (decision uses the pre-pop cheio).
- Pointers are log2(PROFUNDIDADE) bits and wrap modulo PROFUNDIDADE. contagem is the authority for full/empty.
- All outputs are registered or derived from registers only. There are no combinational paths from inputs to outputs.

Decomposition:
- Package fila_pkg holds:
  - the FSM state encodings (DESLIGADO=000, ESPERA=001, CAPTURA=010, CHECA=011, GRAVA=100, DESCARTA=101);
  - the motivo codes (MOT_NENHUM=00, MOT_INVALIDO=01, MOT_CHEIA=10, MOT_DUPLICADO=11).
- One sub-module: sincroniza_borda, the 2-FF synchronizer plus rising-edge detector (1-bit in, 1-bit pulse out, clock/reset).
- FIFO storage, duplicate comparators and the FSM stay in the top module.

Test Plan:
1. Reset low 10 cycles, iniciar=1, origem=1, destino=4, novaEntrada high 50 cycles → exactly one entry; valido=1 by E+4; cab=(1,4); contagem=1; rejeitado never pulses.
2. origem=3, destino=3 strobe, then origem=2, destino=9 strobe → two rejeitado pulses; motivo=01 after each; contagem unchanged.
3. Enqueue (1,4), (2,6), (8,3), (0,5) with no pop, then (4,7) → cheio=1; fifth request gives rejeitado with motivo=10; head still (1,4).
4. Enqueue (2,6) twice → second strobe rejected with motivo=11, contagem=1; then pop → valido=0; a third (2,6) is accepted.
5. FIFO holds (1,4); pop asserted in the same cycle as GRAVA of (8,3) → contagem stays 1; head=(8,3) next cycle; pointers wrap correctly after 6 more push/pop pairs.
6. Three entries stored, drop iniciar for 1 cycle → contagem=0, valido=0, db_estado=000. Separately, reset asserted during CHECA → no write, all outputs 0 immediately (asynchronous).
